// File: rtl/mm_arbiter.sv
// rtl/mm_arbiter.sv - two-master round-robin arbiter for the 8-bit addr / 16-bit data mm bus
// Grant held for one full transfer; a per-transfer watchdog aborts a slave that never responds.
module mm_arbiter #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic              timeout
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT0, ABORT1} state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  logic              req0, req1, sel, other_req, g_wait;
  state_t            other_gnt;
  logic [DATA_W-1:0] g_rdata;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  // sel names the master owning the bus in GNT/ABORT states
  assign sel     = (state_q == GNT1) || (state_q == ABORT1);
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    wdog_d         = wdog_q;
    timeout_d      = timeout_q;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    g_wait         = 1'b1;
    g_rdata        = '0;
    other_req      = sel ? req0 : req1;
    other_gnt      = sel ? GNT0 : GNT1;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) state_d = GNT0;
        else if (req1)                 state_d = GNT1;
      end
      GNT0, GNT1: begin
        s_address   = sel ? m1_address : m0_address;
        s_write     = sel ? m1_write : m0_write;
        s_read      = sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
        s_writedata = sel ? m1_writedata : m0_writedata;
        g_wait      = s_waitrequest;
        g_rdata     = s_readdata;
        // completion beats the watchdog when both land on the same cycle
        if (!s_waitrequest) begin
          last_d  = sel;
          wdog_d  = '0;
          state_d = other_req ? other_gnt : IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = sel ? ABORT1 : ABORT0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ABORT0, ABORT1: begin
        g_wait    = 1'b0;
        g_rdata   = ERR_DATA;
        timeout_d = 1'b1;
        last_d    = sel;
        wdog_d    = '0;
        state_d   = other_req ? other_gnt : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sel) begin
      m1_waitrequest = g_wait;
      m1_readdata    = g_rdata;
    end else begin
      m0_waitrequest = g_wait;
      m0_readdata    = g_rdata;
    end

    if (!rst_n) begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_readdata    = '0;
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// tb/tb_mm_arbiter.sv - self-checking bench for mm_arbiter
module tb_mm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata, s_readdata;
  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest, timeout;

  int checks = 0;
  int failures = 0;
  int ws = 0;
  bit hold = 1'b0;
  int scnt = 0;
  bit done0, done1;

  always #5 clk = ~clk;

  mm_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest), .timeout(timeout)
  );

  // slave: ws wait states per transfer (or stalls forever when hold), readdata = address
  always @(posedge clk) begin
    if ((s_read | s_write) && s_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
  end
  assign s_waitrequest = (s_read | s_write) ? (hold || (scnt < ws)) : 1'b1;
  assign s_readdata    = {8'h00, s_address};

  typedef struct {
    int          m;
    bit          wr;
    bit          ab;
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    bit en0; bit rd0; bit wr0; logic [7:0] a0; logic [15:0] d0;
    bit en1; bit rd1; bit wr1; logic [7:0] a1; logic [15:0] d1;
    int ws;
    int first;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[6];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(int m, bit wr, bit ab, logic [7:0] a, logic [15:0] d);
    exp_t e;
    e.m = m; e.wr = wr; e.ab = ab; e.a = a; e.d = d;
    return e;
  endfunction

  function automatic vec_t mkv(bit en0, bit rd0, bit wr0, logic [7:0] a0, logic [15:0] d0,
                               bit en1, bit rd1, bit wr1, logic [7:0] a1, logic [15:0] d1,
                               int w, int first);
    vec_t v;
    v.en0 = en0; v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
    v.en1 = en1; v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
    v.ws = w; v.first = first;
    return v;
  endfunction

  // called each negedge: a low master waitrequest marks a completed or aborted transfer
  task automatic sample();
    exp_t e;
    int m;
    m = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
    if (m == -1) return;
    chk("single_grant", {31'b0, m0_waitrequest | m1_waitrequest}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected got=master%0d required=no_event", m);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_master", m, e.m);
    if (e.ab) begin
      chk("abort_s_cmd", {30'b0, s_read, s_write}, 32'd0);
      chk("abort_rdata", (m == 1) ? m1_readdata : m0_readdata, 32'hDEAD);
    end else begin
      chk("sb_s_cmd", {30'b0, s_read, s_write}, {30'b0, ~e.wr, e.wr});
      chk("sb_addr", s_address, e.a);
      if (e.wr) chk("sb_wdata", s_writedata, e.d);
      else chk("sb_rdata", (m == 1) ? m1_readdata : m0_readdata, {8'h00, e.a});
    end
  endtask

  task automatic op(int m, bit rd, bit wr, logic [7:0] a, logic [15:0] d);
    bit ok;
    ok = 1'b0;
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("op_completed", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic rel(int m);
    if (m == 0) begin
      m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
    end else begin
      m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
    end
  endtask

  task automatic monitor();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      sample();
      if (done0 && done1) break;
    end
  endtask

  task automatic do_reset(bit check_out);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    if (check_out) begin
      @(negedge clk);
      chk("rst_wait", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);
      chk("rst_s_cmd", {30'b0, s_read, s_write}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    ws = v.ws;
    if (v.first == 0) begin
      if (v.en0) exp_q.push_back(mk(0, v.wr0, 0, v.a0, v.d0));
      if (v.en1) exp_q.push_back(mk(1, v.wr1, 0, v.a1, v.d1));
    end else begin
      if (v.en1) exp_q.push_back(mk(1, v.wr1, 0, v.a1, v.d1));
      if (v.en0) exp_q.push_back(mk(0, v.wr0, 0, v.a0, v.d0));
    end
    done0 = !v.en0;
    done1 = !v.en1;
    @(posedge clk);
    #1;
    fork
      begin
        if (v.en0) begin op(0, v.rd0, v.wr0, v.a0, v.d0); rel(0); done0 = 1'b1; end
      end
      begin
        if (v.en1) begin op(1, v.rd1, v.wr1, v.a1, v.d1); rel(1); done1 = 1'b1; end
      end
      monitor();
    join
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=stuck required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rel(0);
    rel(1);

    tbl[0] = mkv(1, 1, 0, 8'h02, 16'h0000, 1, 1, 0, 8'h03, 16'h0000, 2, 0);
    tbl[1] = mkv(1, 1, 0, 8'h01, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
    tbl[2] = mkv(0, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 8'h05, 16'h1234, 3, 1);
    tbl[3] = mkv(1, 0, 1, 8'h10, 16'hAAAA, 1, 1, 0, 8'h20, 16'h0000, 1, 0);
    tbl[4] = mkv(1, 1, 1, 8'h33, 16'h5555, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
    tbl[5] = mkv(1, 1, 0, 8'h40, 16'h0000, 1, 1, 0, 8'h41, 16'h0000, 0, 1);

    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_s_bus", {21'b0, s_read, s_write, s_address}, 32'd0);
      chk("idle_wait", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);
    end

    // one cycle of arbitration latency on a 0-wait read
    @(posedge clk);
    #1;
    m0_read = 1'b1;
    m0_address = 8'h01;
    @(negedge clk);
    chk("lat_s_read_low", {31'b0, s_read}, 32'd0);
    @(negedge clk);
    chk("lat_s_read_high", {31'b0, s_read}, 32'd1);
    chk("lat_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
    chk("lat_m0_rdata", m0_readdata, 32'd1);
    chk("lat_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    rel(0);

    do_reset(1'b0);
    foreach (tbl[i]) run_vec(tbl[i]);

    // write held on the slave for wait states + 1 cycles
    ws = 2;
    n = 0;
    @(posedge clk);
    #1;
    m1_write = 1'b1;
    m1_address = 8'h05;
    m1_writedata = 16'h1234;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_write) n++;
      if (!m1_waitrequest) break;
    end
    chk("wr_cycles", n, 32'd3);
    chk("wr_addr", s_address, 32'h05);
    chk("wr_data", s_writedata, 32'h1234);
    @(posedge clk);
    #1;
    rel(1);

    // fairness under continuous requests
    do_reset(1'b0);
    ws = 1;
    exp_q.push_back(mk(0, 0, 0, 8'h50, 16'h0));
    exp_q.push_back(mk(1, 0, 0, 8'h51, 16'h0));
    exp_q.push_back(mk(0, 0, 0, 8'h52, 16'h0));
    exp_q.push_back(mk(1, 0, 0, 8'h53, 16'h0));
    done0 = 1'b0;
    done1 = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin op(0, 1, 0, 8'h50, 16'h0); op(0, 1, 0, 8'h52, 16'h0); rel(0); done0 = 1'b1; end
      begin op(1, 1, 0, 8'h51, 16'h0); op(1, 1, 0, 8'h53, 16'h0); rel(1); done1 = 1'b1; end
      monitor();
    join
    chk("fair_drained", exp_q.size(), 32'd0);

    // watchdog abort with a slave that never drops waitrequest
    hold = 1'b1;
    n = 0;
    @(posedge clk);
    #1;
    m0_read = 1'b1;
    m0_address = 8'h07;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n++;
      if (!m0_waitrequest) break;
    end
    chk("to_latency", n, 32'd10);
    chk("to_rdata", m0_readdata, 32'hDEAD);
    chk("to_s_read", {31'b0, s_read}, 32'd0);
    @(posedge clk);
    #1;
    rel(0);
    hold = 1'b0;
    ws = 0;
    @(negedge clk);
    chk("to_flag_set", {31'b0, timeout}, 32'd1);
    chk("to_released", {31'b0, m0_waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    m1_read = 1'b1;
    m1_address = 8'h09;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!m1_waitrequest) begin n = 1; break; end
    end
    chk("post_to_done", n, 32'd1);
    chk("post_to_rdata", m1_readdata, 32'h0009);
    chk("to_flag_sticky", {31'b0, timeout}, 32'd1);
    @(posedge clk);
    #1;
    rel(1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
